// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch/decode front end: opcodes, fetch FSM
// state encoding and the default reset vector.
package mips_pkg;

   localparam logic [5:0]  OP_RTYPE = 6'b000000;
   localparam logic [5:0]  OP_J     = 6'b000010;
   localparam logic [5:0]  OP_BEQ   = 6'b000100;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_RST   = 2'b00,
      ST_FETCH = 2'b01,
      ST_ISSUE = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory req/ack bus. The fetch unit is the master; the
// instruction memory (or a bench model of it) is the slave.
interface instruction_fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ack, input  imem_rdata);

   modport slave  (input  imem_req, input  imem_addr,
                   output imem_ack, output imem_rdata);

endinterface

// File: rtl/instruction_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection for the fetch stage: Jump beats a taken
// branch, which beats sequential flow. All adds wrap modulo 2^32.
module next_pc_logic (
   input  logic [31:0] pc_i,
   input  logic [31:0] ir_i,
   input  logic        branch_i,
   input  logic        jump_i,
   input  logic        zero_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] next_pc_o
);

   logic [31:0] branch_off;
   logic [31:0] jump_target;

   assign pc_plus4_o  = pc_i + 32'd4;
   assign branch_off  = {{14{ir_i[15]}}, ir_i[15:0], 2'b00};
   assign jump_target = {pc_plus4_o[31:28], ir_i[25:0], 2'b00};

   always_comb begin
      next_pc_o = pc_plus4_o;
      if (jump_i) begin
         next_pc_o = jump_target;
      end else if (branch_i && zero_i) begin
         next_pc_o = pc_plus4_o + branch_off;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, fetches over the req/ack bus into the
// instruction register, and advances the PC when the datapath retires.
module instruction_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          ADDR_W   = 32
) (
   input  logic                      CLK,
   input  logic                      Reset_L,
   instruction_fetch_unit_if.master  imem,
   output logic [31:0]               inst_out,
   output logic                      inst_valid,
   output logic [5:0]                Opcode,
   output logic [5:0]                FuncCode,
   output logic [31:0]               PCPlus4,
   input  logic                      inst_accept,
   input  logic                      Branch,
   input  logic                      Jump,
   input  logic                      Zero,
   output logic [31:0]               inst_count
);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [31:0]       ir_q;
   logic [31:0]       count_q;
   logic              req_q;
   logic              valid_q;
   logic [31:0]       next_pc;

   next_pc_logic u_next_pc (
      .pc_i       (pc_q),
      .ir_i       (ir_q),
      .branch_i   (Branch),
      .jump_i     (Jump),
      .zero_i     (Zero),
      .pc_plus4_o (PCPlus4),
      .next_pc_o  (next_pc)
   );

   // NOTE: the reset branch is asynchronous so imem_req drops the moment
   // Reset_L falls, abandoning any request in flight.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q <= ST_RST;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         count_q <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update in this
         // block reading pre-edge values, regardless of statement order.
         case (state_q)
            ST_RST: begin
               // A late ack from before reset may still be on the bus; ignore it.
               state_q <= ST_FETCH;
               req_q   <= 1'b1;
            end
            ST_FETCH: begin
               if (imem.imem_ack) begin
                  ir_q    <= imem.imem_rdata;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (inst_accept) begin
                  pc_q    <= next_pc;
                  count_q <= count_q + 32'd1;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= ST_FETCH;
               end
            end
            default: begin
               state_q <= ST_RST;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = {pc_q[31:2], 2'b00};
   assign inst_out       = ir_q;
   assign inst_valid     = valid_q;
   assign Opcode         = ir_q[31:26];
   assign FuncCode       = ir_q[5:0];
   assign inst_count     = count_q;

endmodule
